// File: rtl/ps2_kb_rx.sv
// PS/2 keyboard receiver: frame decoder, make/break/extended tagging, scan-code FIFO and WASD tracking.
// Define PS2_KB_TIMEOUT_EN to abort partial frames after TIMEOUT_CYCLES without a PS/2 clock edge.
module ps2_kb_rx #(
    parameter int FIFO_DEPTH     = 4,
    parameter int TIMEOUT_CYCLES = 50000
) (
    input  logic       clock,
    input  logic       reset,
    input  logic       ps2_clk,
    input  logic       ps2_data,
    input  logic       rd_en,
    output logic       code_valid,
    output logic [9:0] code_data,
    output logic       overflow,
    output logic       frame_err,
    output logic [3:0] keys_held,
    output logic [2:0] dir
);

    localparam int AW = $clog2(FIFO_DEPTH);

    typedef enum logic [1:0] {IDLE, DATA, PARITY, STOP} state_t;

    function automatic logic odd_parity_ok(input logic [7:0] b, input logic p);
        return ^{b, p};
    endfunction

    function automatic logic [3:0] key_update(input logic [3:0] keys, input logic [7:0] code,
                                              input logic release_key);
        logic [3:0] mask;
        mask = 4'b0000;
        case (code)
            8'h1D:   mask = 4'b1000;
            8'h1B:   mask = 4'b0100;
            8'h1C:   mask = 4'b0010;
            8'h23:   mask = 4'b0001;
            default: mask = 4'b0000;
        endcase
        return release_key ? (keys & ~mask) : (keys | mask);
    endfunction

    // Stage p0/p1: synchronisers; p2: previous synced clock for falling-edge detect
    logic ps2_clk_p0, ps2_clk_p1, ps2_clk_p2;
    logic ps2_data_p0, ps2_data_p1;

    always_ff @(posedge clock) begin
        if (reset) begin
            ps2_clk_p0  <= 1'b1;
            ps2_clk_p1  <= 1'b1;
            ps2_clk_p2  <= 1'b1;
            ps2_data_p0 <= 1'b1;
            ps2_data_p1 <= 1'b1;
        end else begin
            ps2_clk_p0  <= ps2_clk;
            ps2_clk_p1  <= ps2_clk_p0;
            ps2_clk_p2  <= ps2_clk_p1;
            ps2_data_p0 <= ps2_data;
            ps2_data_p1 <= ps2_data_p0;
        end
    end

    logic fall;
    logic bit_in;
    assign fall   = ps2_clk_p2 & ~ps2_clk_p1;
    assign bit_in = ps2_data_p1;

    state_t     state;
    logic [2:0] bit_cnt;
    logic [7:0] shift;
    logic       ext;
    logic       brk;
    logic       timeout;

    logic frame_done;
    logic is_prefix;
    logic push;
    assign frame_done = fall && (state == STOP) && bit_in;
    assign is_prefix  = (shift == 8'hE0) || (shift == 8'hF0);
    assign push       = frame_done && !is_prefix;

`ifdef PS2_KB_TIMEOUT_EN
    localparam int TMO_W = $clog2(TIMEOUT_CYCLES + 1);
    logic [TMO_W-1:0] tmo_cnt;

    always_ff @(posedge clock) begin
        if (reset || (state == IDLE) || fall) begin
            tmo_cnt <= '0;
        end else begin
            tmo_cnt <= tmo_cnt + 1'b1;
        end
    end

    assign timeout = (state != IDLE) && !fall && (tmo_cnt == TMO_W'(TIMEOUT_CYCLES - 1));
`else
    // Without the timeout the receiver waits indefinitely for the next edge.
    assign timeout = (TIMEOUT_CYCLES < 0);
`endif

    always_ff @(posedge clock) begin
        if (reset) begin
            state     <= IDLE;
            bit_cnt   <= 3'd0;
            shift     <= 8'h00;
            ext       <= 1'b0;
            brk       <= 1'b0;
            frame_err <= 1'b0;
            keys_held <= 4'b0000;
        end else begin
            frame_err <= 1'b0;
            if (timeout) begin
                state     <= IDLE;
                frame_err <= 1'b1;
                ext       <= 1'b0;
                brk       <= 1'b0;
            end else if (fall) begin
                case (state)
                    IDLE: begin
                        if (!bit_in) begin
                            state   <= DATA;
                            bit_cnt <= 3'd0;
                        end
                    end
                    DATA: begin
                        shift   <= {bit_in, shift[7:1]};
                        bit_cnt <= bit_cnt + 3'd1;
                        if (bit_cnt == 3'd7) state <= PARITY;
                    end
                    PARITY: begin
                        if (odd_parity_ok(shift, bit_in)) begin
                            state <= STOP;
                        end else begin
                            state     <= IDLE;
                            frame_err <= 1'b1;
                        end
                    end
                    STOP: begin
                        state <= IDLE;
                        if (!bit_in) begin
                            frame_err <= 1'b1;
                        end else if (shift == 8'hE0) begin
                            ext <= 1'b1;
                        end else if (shift == 8'hF0) begin
                            brk <= 1'b1;
                        end else begin
                            ext <= 1'b0;
                            brk <= 1'b0;
                            if (!ext) keys_held <= key_update(keys_held, shift, brk);
                        end
                    end
                    default: state <= IDLE;
                endcase
            end
        end
    end

    // Scan-code FIFO: extra pointer bit separates full from empty
    logic [AW:0] wr_ptr, rd_ptr;
    logic [9:0]  mem [FIFO_DEPTH];
    logic        empty, full, pop, accept;

    assign empty  = (wr_ptr == rd_ptr);
    assign full   = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
    assign pop    = rd_en && !empty;
    assign accept = push && (!full || pop);

    always_ff @(posedge clock) begin
        if (reset) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            overflow <= 1'b0;
        end else begin
            if (accept) wr_ptr <= wr_ptr + 1'b1;
            if (pop)    rd_ptr <= rd_ptr + 1'b1;
            if (push && !accept) overflow <= 1'b1;
        end
    end

    always_ff @(posedge clock) begin
        if (accept) mem[wr_ptr[AW-1:0]] <= {brk, ext, shift};
    end

    assign code_valid = !empty;
    assign code_data  = empty ? 10'h000 : mem[rd_ptr[AW-1:0]];

    always_comb begin
        dir = 3'd0;
        if (keys_held[3])      dir = 3'd3;
        else if (keys_held[2]) dir = 3'd4;
        else if (keys_held[1]) dir = 3'd1;
        else if (keys_held[0]) dir = 3'd2;
    end

endmodule

// File: tb/tb_ps2_kb_rx.sv
// Directed bench for ps2_kb_rx: bit-banged PS/2 frames with hand-computed expected codes.
module tb_ps2_kb_rx;

    localparam int DEPTH = 4;
    localparam int TMO   = 300;
    localparam int HALF  = 8;

    logic       clock = 1'b0;
    logic       reset, ps2_clk, ps2_data, rd_en;
    logic       code_valid, overflow, frame_err;
    logic [9:0] code_data;
    logic [3:0] keys_held;
    logic [2:0] dir;

    int n_checks = 0;
    int n_fail   = 0;
    int err_cnt  = 0;

    ps2_kb_rx #(.FIFO_DEPTH(DEPTH), .TIMEOUT_CYCLES(TMO)) dut (
        .clock(clock), .reset(reset), .ps2_clk(ps2_clk), .ps2_data(ps2_data), .rd_en(rd_en),
        .code_valid(code_valid), .code_data(code_data), .overflow(overflow),
        .frame_err(frame_err), .keys_held(keys_held), .dir(dir)
    );

    always #5 clock = ~clock;

    always @(posedge clock) if (frame_err === 1'b1) err_cnt <= err_cnt + 1;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish, actual running, required finished");
        $fatal(1, "watchdog");
    end

    task automatic do_reset();
        reset = 1'b1; ps2_clk = 1'b1; ps2_data = 1'b1; rd_en = 1'b0;
        repeat (4) @(negedge clock);
        reset = 1'b0;
        @(negedge clock);
    endtask

    task automatic ps2_bit(input logic b);
        @(negedge clock);
        ps2_data = b;
        repeat (HALF) @(negedge clock);
        ps2_clk = 1'b0;
        repeat (HALF) @(negedge clock);
        ps2_clk = 1'b1;
    endtask

    task automatic send_frame(input logic [7:0] b, input logic bad_par, input logic bad_stop);
        ps2_bit(1'b0);
        for (int i = 0; i < 8; i++) ps2_bit(b[i]);
        ps2_bit((~^b) ^ bad_par);
        ps2_bit(~bad_stop);
        ps2_data = 1'b1;
        repeat (HALF) @(negedge clock);
    endtask

    task automatic pop();
        rd_en = 1'b1;
        @(negedge clock);
        rd_en = 1'b0;
    endtask

    task automatic test_reset();
        do_reset();
        n_checks++; if (code_valid !== 1'b0) begin n_fail++; $display("FAIL reset_valid got %b want 0", code_valid); end
        n_checks++; if (code_data !== 10'h000) begin n_fail++; $display("FAIL reset_data got %h want 000", code_data); end
        n_checks++; if (overflow !== 1'b0) begin n_fail++; $display("FAIL reset_ovf got %b want 0", overflow); end
        n_checks++; if (frame_err !== 1'b0) begin n_fail++; $display("FAIL reset_ferr got %b want 0", frame_err); end
        n_checks++; if (keys_held !== 4'b0000) begin n_fail++; $display("FAIL reset_keys got %b want 0000", keys_held); end
        n_checks++; if (dir !== 3'd0) begin n_fail++; $display("FAIL reset_dir got %0d want 0", dir); end
    endtask

    task automatic test_make_break();
        do_reset();
        send_frame(8'h1D, 1'b0, 1'b0);
        n_checks++; if (code_valid !== 1'b1) begin n_fail++; $display("FAIL make_valid got %b want 1", code_valid); end
        n_checks++; if (code_data !== 10'h01D) begin n_fail++; $display("FAIL make_data got %h want 01d", code_data); end
        n_checks++; if (keys_held !== 4'b1000) begin n_fail++; $display("FAIL make_keys got %b want 1000", keys_held); end
        n_checks++; if (dir !== 3'd3) begin n_fail++; $display("FAIL make_dir got %0d want 3", dir); end
        pop();
        n_checks++; if (code_valid !== 1'b0) begin n_fail++; $display("FAIL pop_empty got %b want 0", code_valid); end
        send_frame(8'hF0, 1'b0, 1'b0);
        n_checks++; if (code_valid !== 1'b0) begin n_fail++; $display("FAIL f0_nopush got %b want 0", code_valid); end
        send_frame(8'h1D, 1'b0, 1'b0);
        n_checks++; if (code_data !== 10'h21D) begin n_fail++; $display("FAIL break_data got %h want 21d", code_data); end
        n_checks++; if (keys_held !== 4'b0000) begin n_fail++; $display("FAIL break_keys got %b want 0000", keys_held); end
        n_checks++; if (dir !== 3'd0) begin n_fail++; $display("FAIL break_dir got %0d want 0", dir); end
        pop();
    endtask

    task automatic test_ext();
        do_reset();
        send_frame(8'h1C, 1'b0, 1'b0);
        pop();
        n_checks++; if (dir !== 3'd1) begin n_fail++; $display("FAIL a_dir got %0d want 1", dir); end
        send_frame(8'hE0, 1'b0, 1'b0);
        send_frame(8'h75, 1'b0, 1'b0);
        n_checks++; if (code_data !== 10'h175) begin n_fail++; $display("FAIL ext_data got %h want 175", code_data); end
        n_checks++; if (keys_held !== 4'b0010) begin n_fail++; $display("FAIL ext_keys got %b want 0010", keys_held); end
        pop();
        send_frame(8'hE0, 1'b0, 1'b0);
        send_frame(8'h1D, 1'b0, 1'b0);
        n_checks++; if (code_data !== 10'h11D) begin n_fail++; $display("FAIL ext1d_data got %h want 11d", code_data); end
        n_checks++; if (keys_held !== 4'b0010) begin n_fail++; $display("FAIL ext1d_keys got %b want 0010", keys_held); end
        pop();
        send_frame(8'h15, 1'b0, 1'b0);
        n_checks++; if (code_data !== 10'h015) begin n_fail++; $display("FAIL flags_clear got %h want 015", code_data); end
        pop();
    endtask

    task automatic test_frame_errors();
        int e0;
        do_reset();
        e0 = err_cnt;
        send_frame(8'h1C, 1'b1, 1'b0);
        n_checks++; if (err_cnt - e0 !== 1) begin n_fail++; $display("FAIL par_pulses got %0d want 1", err_cnt - e0); end
        n_checks++; if (code_valid !== 1'b0) begin n_fail++; $display("FAIL par_nopush got %b want 0", code_valid); end
        n_checks++; if (keys_held !== 4'b0000) begin n_fail++; $display("FAIL par_keys got %b want 0000", keys_held); end
        e0 = err_cnt;
        send_frame(8'h1C, 1'b0, 1'b1);
        n_checks++; if (err_cnt - e0 !== 1) begin n_fail++; $display("FAIL stop_pulses got %0d want 1", err_cnt - e0); end
        n_checks++; if (code_valid !== 1'b0) begin n_fail++; $display("FAIL stop_nopush got %b want 0", code_valid); end
        send_frame(8'h1C, 1'b0, 1'b0);
        n_checks++; if (code_data !== 10'h01C) begin n_fail++; $display("FAIL recover_data got %h want 01c", code_data); end
        n_checks++; if (keys_held !== 4'b0010) begin n_fail++; $display("FAIL recover_keys got %b want 0010", keys_held); end
    endtask

    task automatic test_overflow();
        logic [7:0] codes [5];
        codes = '{8'h15, 8'h16, 8'h1E, 8'h26, 8'h25};
        do_reset();
        rd_en = 1'b1;
        @(negedge clock);
        rd_en = 1'b0;
        for (int i = 0; i < DEPTH + 1; i++) send_frame(codes[i], 1'b0, 1'b0);
        n_checks++; if (overflow !== 1'b1) begin n_fail++; $display("FAIL ovf_set got %b want 1", overflow); end
        for (int i = 0; i < DEPTH; i++) begin
            n_checks++;
            if (code_data !== {2'b00, codes[i]}) begin
                n_fail++; $display("FAIL ovf_order%0d got %h want %h", i, code_data, {2'b00, codes[i]});
            end
            pop();
        end
        n_checks++; if (code_valid !== 1'b0) begin n_fail++; $display("FAIL ovf_drain got %b want 0", code_valid); end
        n_checks++; if (overflow !== 1'b1) begin n_fail++; $display("FAIL ovf_sticky got %b want 1", overflow); end
    endtask

    task automatic test_back_to_back();
        do_reset();
        send_frame(8'h1B, 1'b0, 1'b0);
        send_frame(8'h23, 1'b0, 1'b0);
        n_checks++; if (keys_held !== 4'b0101) begin n_fail++; $display("FAIL b2b_keys got %b want 0101", keys_held); end
        n_checks++; if (dir !== 3'd4) begin n_fail++; $display("FAIL b2b_dir got %0d want 4", dir); end
        n_checks++; if (code_data !== 10'h01B) begin n_fail++; $display("FAIL b2b_first got %h want 01b", code_data); end
        pop();
        n_checks++; if (code_data !== 10'h023) begin n_fail++; $display("FAIL b2b_second got %h want 023", code_data); end
        pop();
        send_frame(8'h1C, 1'b0, 1'b0);
        n_checks++; if (dir !== 3'd4) begin n_fail++; $display("FAIL prio_down got %0d want 4", dir); end
        send_frame(8'hF0, 1'b0, 1'b0);
        send_frame(8'h1B, 1'b0, 1'b0);
        n_checks++; if (dir !== 3'd1) begin n_fail++; $display("FAIL prio_left got %0d want 1", dir); end
        send_frame(8'hF0, 1'b0, 1'b0);
        send_frame(8'h1C, 1'b0, 1'b0);
        n_checks++; if (dir !== 3'd2) begin n_fail++; $display("FAIL prio_right got %0d want 2", dir); end
    endtask

    task automatic test_latency();
        logic [7:0] b;
        int n;
        b = 8'h29;
        do_reset();
        ps2_bit(1'b0);
        for (int i = 0; i < 8; i++) ps2_bit(b[i]);
        ps2_bit(~^b);
        @(negedge clock);
        ps2_data = 1'b1;
        repeat (HALF) @(negedge clock);
        ps2_clk = 1'b0;
        n = 0;
        while (n < 20) begin
            @(posedge clock);
            #1;
            n++;
            if (code_valid === 1'b1) break;
        end
        n_checks++; if (n !== 3) begin n_fail++; $display("FAIL push_latency got %0d cycles want 3", n); end
        repeat (HALF) @(negedge clock);
        ps2_clk = 1'b1;
        n_checks++; if (code_data !== 10'h029) begin n_fail++; $display("FAIL latency_data got %h want 029", code_data); end
    endtask

    task automatic test_reset_mid_frame();
        do_reset();
        ps2_bit(1'b0);
        ps2_bit(1'b1);
        ps2_bit(1'b0);
        do_reset();
        send_frame(8'h1D, 1'b0, 1'b0);
        n_checks++; if (code_data !== 10'h01D) begin n_fail++; $display("FAIL midreset_data got %h want 01d", code_data); end
        n_checks++; if (keys_held !== 4'b1000) begin n_fail++; $display("FAIL midreset_keys got %b want 1000", keys_held); end
    endtask

`ifdef PS2_KB_TIMEOUT_EN
    task automatic test_timeout();
        int e0;
        do_reset();
        send_frame(8'hE0, 1'b0, 1'b0);
        e0 = err_cnt;
        ps2_bit(1'b0);
        for (int i = 0; i < 4; i++) ps2_bit(1'b1);
        repeat (TMO + 20) @(negedge clock);
        n_checks++; if (err_cnt - e0 !== 1) begin n_fail++; $display("FAIL tmo_pulses got %0d want 1", err_cnt - e0); end
        send_frame(8'h23, 1'b0, 1'b0);
        n_checks++; if (code_data !== 10'h023) begin n_fail++; $display("FAIL tmo_data got %h want 023", code_data); end
        n_checks++; if (dir !== 3'd2) begin n_fail++; $display("FAIL tmo_dir got %0d want 2", dir); end
    endtask
`endif

    initial begin
        reset = 1'b1; ps2_clk = 1'b1; ps2_data = 1'b1; rd_en = 1'b0;
        test_reset();
        test_make_break();
        test_ext();
        test_frame_errors();
        test_overflow();
        test_back_to_back();
        test_latency();
        test_reset_mid_frame();
`ifdef PS2_KB_TIMEOUT_EN
        test_timeout();
`endif
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
